// File: rtl/buzz_pkg.sv
// -----------------------------------------------------------------------------
// buzz_pkg
// Shared definitions for the buzzer note player:
//   - note code constants (C4..B4 = 0..6, rest = 7)
//   - half-period table in 50 MHz clock cycles, one entry per note code
//   - note request record (code + duration) as carried through the FIFO
//   - player FSM state encoding
//   - half_period(): table lookup with right-shift and clamp to 1
// -----------------------------------------------------------------------------
package buzz_pkg;

    localparam logic [2:0] NOTE_C4   = 3'd0;
    localparam logic [2:0] NOTE_D4   = 3'd1;
    localparam logic [2:0] NOTE_E4   = 3'd2;
    localparam logic [2:0] NOTE_F4   = 3'd3;
    localparam logic [2:0] NOTE_G4   = 3'd4;
    localparam logic [2:0] NOTE_A4   = 3'd5;
    localparam logic [2:0] NOTE_B4   = 3'd6;
    localparam logic [2:0] NOTE_REST = 3'd7;

    // Widths of the half-period/divider path and of one queued request.
    localparam int HP_W  = 17;
    localparam int REQ_W = 11;

    // Half period of each note at 50 MHz (clk cycles per speaker level).
    // The rest entry is 0; it is never used to drive the speaker.
    localparam logic [HP_W-1:0] NOTE_HP [8] = '{
        17'd95556,  // C4
        17'd85131,  // D4
        17'd75843,  // E4
        17'd71586,  // F4
        17'd63776,  // G4
        17'd56818,  // A4
        17'd50619,  // B4
        17'd0       // rest
    };

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] dur;
    } note_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Scaled half period. A scaled value of 0 would make the divider
    // compare against all-ones and stall, so it is clamped to 1.
    function automatic logic [HP_W-1:0] half_period(input logic [2:0] code,
                                                    input int         shift);
        logic [HP_W-1:0] hp;
        hp = NOTE_HP[code] >> shift;
        if (hp == '0) begin
            hp = 17'd1;
        end
        return hp;
    endfunction

endpackage

// File: rtl/buzz_note_fifo.sv
// -----------------------------------------------------------------------------
// buzz_note_fifo
// Synchronous DEPTH x WIDTH request FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers only)
//   push       : write wdata when not full
//   pop        : advance the read pointer when not empty
//   wdata      : data to write
//   rdata      : head entry (combinational read of the head slot)
//   full/empty : derived from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module buzz_note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointer difference is the occupancy; the wrap bit makes DEPTH
    // representable without aliasing to 0.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset: stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/buzz_note_player.sv
// -----------------------------------------------------------------------------
// buzz_note_player
// Accepts note requests over valid/ready, queues up to DEPTH of them and
// plays each one as a square wave on the speaker pin, followed by a silent
// articulation gap of GAP_TICKS ticks.
//   clk, rst_n  : 50 MHz clock, asynchronous active-low reset
//   note_valid  : request present
//   note_ready  : FIFO can accept (registered !full)
//   note_code   : 0..6 = C4..B4, 7 = rest
//   note_dur    : duration in ticks of TICK_CLKS cycles
//   speaker     : square-wave buzzer drive (registered)
//   busy        : FSM not idle or FIFO not empty
//   cur_code    : code currently sounding, 7 when silent (registered)
//
// Handshake: a request transfers on a rising clk edge where note_valid and
// note_ready are both high. note_ready depends only on registered FIFO
// state, so a full FIFO refuses a push even in a cycle where it pops.
// -----------------------------------------------------------------------------
module buzz_note_player
    import buzz_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TICK_CLKS = 500000,
    parameter int GAP_TICKS = 2,
    parameter int HP_SHIFT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [2:0] note_code,
    input  logic [7:0] note_dur,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] cur_code
);

    // Prescaler width; kept at least 1 bit for degenerate TICK_CLKS.
    localparam int              PW       = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_CLKS - 1);
    localparam logic [7:0]      GAP_LEN  = 8'(GAP_TICKS);

    state_t          state;
    note_req_t       push_req;
    note_req_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

    logic [2:0]      req_code;
    logic [7:0]      req_dur;
    logic [HP_W-1:0] hp;
    logic [HP_W-1:0] div;
    logic [PW-1:0]   pre;
    logic [7:0]      ticks;
    logic            tick_wrap;

    assign push_req   = {note_code, note_dur};
    assign note_ready = !fifo_full;
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign tick_wrap  = (pre == PRE_LAST);

    buzz_note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (note_valid),
        .pop   (fifo_pop),
        .wdata (push_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            req_code <= NOTE_REST;
            req_dur  <= '0;
            hp       <= '0;
            div      <= '0;
            pre      <= '0;
            ticks    <= '0;
            speaker  <= 1'b0;
            cur_code <= NOTE_REST;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The head is captured on the same edge that pops it.
                    if (!fifo_empty) begin
                        req_code <= head.code;
                        req_dur  <= head.dur;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    hp      <= half_period(req_code, HP_SHIFT);
                    div     <= '0;
                    pre     <= '0;
                    ticks   <= req_dur;
                    speaker <= 1'b0;
                    if (req_dur == 8'd0) begin
                        // Zero-length request: skipped, no gap follows.
                        cur_code <= NOTE_REST;
                        state    <= ST_IDLE;
                    end else begin
                        cur_code <= req_code;
                        state    <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (tick_wrap) begin
                        pre   <= '0;
                        ticks <= ticks - 8'd1;
                    end else begin
                        pre <= pre + 1'b1;
                    end

                    if (div == hp - 17'd1) begin
                        div <= '0;
                        if (req_code != NOTE_REST) begin
                            speaker <= ~speaker;
                        end
                    end else begin
                        div <= div + 17'd1;
                    end

                    // Last tick of the note: silence wins over a toggle
                    // that lands on the same edge.
                    if (tick_wrap && ticks == 8'd1) begin
                        speaker  <= 1'b0;
                        cur_code <= NOTE_REST;
                        div      <= '0;
                        pre      <= '0;
                        if (GAP_TICKS == 0) begin
                            ticks <= '0;
                            state <= ST_IDLE;
                        end else begin
                            ticks <= GAP_LEN;
                            state <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (tick_wrap) begin
                        pre <= '0;
                        if (ticks == 8'd1) begin
                            ticks <= '0;
                            state <= ST_IDLE;
                        end else begin
                            ticks <= ticks - 8'd1;
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
